// File: rtl/mips_mem_pkg.sv
// Shared MIPS memory-access definitions: opcode encodings, load/store unit
// state type and opcode classification helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } lsu_state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword lane of a little-endian memory word and
// sign- or zero-extends it according to the load opcode.
module load_align_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [5:0]  opcode_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
        half_sel = word_i[{byte_off_i[1], 4'b0000} +: 16];
        case (opcode_i)
            OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result_o = {24'd0, byte_sel};
            OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result_o = {16'd0, half_sel};
            OP_LW:   result_o = word_i;
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request at a time, word-addressed memory
// port, read-modify-write for byte/halfword stores, misalignment detection.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            opcode,
    input  logic [31:0]           addr,
    input  logic [31:0]           write_data,
    output logic                  resp_valid,
    output logic [31:0]           load_data,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [31:0]           mem_rdata,
    output logic [2:0]            dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; req_ready is only high in IDLE outside reset,
    // and resp_valid is a single-cycle pulse with load_data/misaligned valid.

    lsu_state_t            state_q;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           load_data_q;
    logic                  misaligned_q;

    logic                  req_mis_d;
    logic                  req_ok_d;
    logic [31:0]           merged_d;
    logic [31:0]           load_ext_d;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign req_mis_d = is_misaligned(opcode, addr[1:0]);
    assign req_ok_d  = is_load(opcode) || is_store(opcode);

    load_align_ext u_align (
        .word_i     (mem_rdata),
        .byte_off_i (addr_q[1:0]),
        .opcode_i   (op_q),
        .result_o   (load_ext_d)
    );

    // Store merge: only the addressed lane is replaced in the fetched word.
    always_comb begin
        merged_d = mem_rdata;
        if (op_q == OP_SB) begin
            merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 6'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            load_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q         <= opcode;
                        addr_q       <= addr[ADDR_WIDTH+1:0];
                        wdata_q      <= write_data;
                        load_data_q  <= 32'd0;
                        misaligned_q <= req_mis_d;
                        if (req_mis_d || !req_ok_d) begin
                            state_q <= S_RESP;
                        end else if (opcode == OP_SW) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (is_store(op_q)) begin
                        wdata_q <= merged_d;
                        state_q <= S_WR;
                    end else begin
                        load_data_q <= load_ext_d;
                        state_q     <= S_RESP;
                    end
                end
                S_WR:    state_q <= S_RESP;
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset removes them at once.
    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = (state_q == S_RESP);
    assign mem_read   = (state_q == S_RD);
    assign mem_write  = (state_q == S_WR);
    assign mem_wdata  = mem_write ? wdata_q : 32'd0;
    assign mem_addr   = addr_q[ADDR_WIDTH+1:2];
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, held-valid and reset-abort
// sequences, and randomized traffic against a word-array reference model.
module tb_load_store_unit;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
    localparam logic [5:0] BAD = 6'h22;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .addr       (addr),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .load_data  (load_data),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Word memory with one-cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    int          rd_total = 0;
    int          wr_total = 0;
    int          resp_total = 0;
    int          acc_total = 0;
    logic [7:0]  last_maddr = 8'd0;
    logic [31:0] last_wdata = 32'd0;
    always @(posedge clk) begin
        if (mem_read) begin
            rd_total   <= rd_total + 1;
            last_maddr <= mem_addr;
        end
        if (mem_write) begin
            wr_total   <= wr_total + 1;
            last_maddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (resp_valid) resp_total <= resp_total + 1;
        if (req_valid && req_ready) acc_total <= acc_total + 1;
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] ref_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] ld, output logic mis,
                          output int nrd, output int nwr);
        int rd0, wr0, n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd0 = rd_total;
        wr0 = wr_total;
        req_valid = 1'b1;
        opcode = op;
        addr = a;
        write_data = wd;
        @(negedge clk);
        req_valid = 1'b0;
        opcode = 6'($urandom);
        addr = $urandom;
        write_data = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        ld = load_data;
        mis = misaligned;
        @(negedge clk);
        nrd = rd_total - rd0;
        nwr = wr_total - wr0;
    endtask

    // Reference model: lane arithmetic on a plain word array
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] ld, output logic mis, output int lat,
                         output int nrd, output int nwr);
        int w, sh;
        logic [31:0] word, b, h, mask;
        w = int'(a[9:2]);
        sh = 8 * int'(a[1:0]);
        word = ref_mem[w];
        b = (word >> sh) & 32'hFF;
        h = (word >> sh) & 32'hFFFF;
        ld = 32'd0; mis = 1'b0; lat = 1; nrd = 0; nwr = 0;
        case (op)
            LB:  begin lat = 3; nrd = 1; ld = (b >= 128) ? b - 32'd256 : b; end
            LBU: begin lat = 3; nrd = 1; ld = b; end
            LH, LHU: begin
                if (a[0]) mis = 1'b1;
                else begin
                    lat = 3; nrd = 1;
                    ld = (op == LH && h >= 32768) ? h - 32'd65536 : h;
                end
            end
            LW: begin
                if (a[1:0] != 0) mis = 1'b1;
                else begin lat = 3; nrd = 1; ld = word; end
            end
            SB: begin
                lat = 4; nrd = 1; nwr = 1;
                mask = 32'hFF << sh;
                ref_mem[w] = (word & ~mask) | ((wd & 32'hFF) << sh);
            end
            SH: begin
                if (a[0]) mis = 1'b1;
                else begin
                    lat = 4; nrd = 1; nwr = 1;
                    mask = 32'hFFFF << sh;
                    ref_mem[w] = (word & ~mask) | ((wd & 32'hFFFF) << sh);
                end
            end
            SW: begin
                if (a[1:0] != 0) mis = 1'b1;
                else begin lat = 2; nwr = 1; ref_mem[w] = wd; end
            end
            default: ;
        endcase
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        mis;
        int          lat;
        int          nrd;
        int          nwr;
        logic [7:0]  maddr;
        logic [31:0] mwd;
    } vec_t;

    vec_t vec[$];

    initial begin
        int lat, nrd, nwr, e_lat, e_rd, e_wr, n, acc0, wr0, resp0, bad;
        logic [31:0] ld, e_ld, a, wd;
        logic mis, e_mis;
        logic [5:0] op;
        logic [5:0] ops [9];

        vec.push_back('{SW,  32'h10,       32'h8000_7F01, 32'h0,         1'b0, 2, 0, 1, 8'h04, 32'h8000_7F01});
        vec.push_back('{LB,  32'h10,       32'h0,         32'h0000_0001, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LB,  32'h13,       32'h0,         32'hFFFF_FF80, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LBU, 32'h13,       32'h0,         32'h0000_0080, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LH,  32'h12,       32'h0,         32'hFFFF_8000, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LHU, 32'h12,       32'h0,         32'h0000_8000, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LW,  32'h10,       32'h0,         32'h8000_7F01, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{SW,  32'h14,       32'h1122_3344, 32'h0,         1'b0, 2, 0, 1, 8'h05, 32'h1122_3344});
        vec.push_back('{SB,  32'h15,       32'hFFFF_FFAB, 32'h0,         1'b0, 4, 1, 1, 8'h05, 32'h1122_AB44});
        vec.push_back('{LW,  32'h14,       32'h0,         32'h1122_AB44, 1'b0, 3, 1, 0, 8'h05, 32'h0});
        vec.push_back('{SH,  32'h16,       32'h1234_BEEF, 32'h0,         1'b0, 4, 1, 1, 8'h05, 32'hBEEF_AB44});
        vec.push_back('{LW,  32'h14,       32'h0,         32'hBEEF_AB44, 1'b0, 3, 1, 0, 8'h05, 32'h0});
        vec.push_back('{LW,  32'h12,       32'h0,         32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0});
        vec.push_back('{SH,  32'h11,       32'h5555,      32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0});
        vec.push_back('{LHU, 32'h13,       32'h0,         32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0});
        vec.push_back('{SW,  32'h16,       32'h9999_9999, 32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0});
        vec.push_back('{LW,  32'h14,       32'h0,         32'hBEEF_AB44, 1'b0, 3, 1, 0, 8'h05, 32'h0});
        vec.push_back('{BAD, 32'h10,       32'h0,         32'h0,         1'b0, 1, 0, 0, 8'h00, 32'h0});
        vec.push_back('{SW,  32'h3FC,      32'hCAFE_F00D, 32'h0,         1'b0, 2, 0, 1, 8'hFF, 32'hCAFE_F00D});
        vec.push_back('{SW,  32'h0,        32'h5A5A_5A5A, 32'h0,         1'b0, 2, 0, 1, 8'h00, 32'h5A5A_5A5A});
        vec.push_back('{LW,  32'h400,      32'h0,         32'h5A5A_5A5A, 1'b0, 3, 1, 0, 8'h00, 32'h0});
        vec.push_back('{LW,  32'hFFFF_FC10, 32'h0,        32'h8000_7F01, 1'b0, 3, 1, 0, 8'h04, 32'h0});
        vec.push_back('{LB,  32'h3FD,      32'h0,         32'hFFFF_FFF0, 1'b0, 3, 1, 0, 8'hFF, 32'h0});
        vec.push_back('{LHU, 32'h3FE,      32'h0,         32'h0000_CAFE, 1'b0, 3, 1, 0, 8'hFF, 32'h0});

        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, BAD};

        // Clock/reset
        reset = 1'b1;
        req_valid = 1'b0;
        opcode = 6'd0;
        addr = 32'd0;
        write_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst req_ready", {31'd0, req_ready}, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst misaligned", {31'd0, misaligned}, 32'd0);
        check("rst mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst release req_ready", {31'd0, req_ready}, 32'd1);

        // Directed vector table
        foreach (vec[i]) begin
            do_req(vec[i].op, vec[i].a, vec[i].wd, lat, ld, mis, nrd, nwr);
            check($sformatf("v%0d latency", i), lat, vec[i].lat);
            check($sformatf("v%0d load_data", i), ld, vec[i].ld);
            check($sformatf("v%0d misaligned", i), {31'd0, mis}, {31'd0, vec[i].mis});
            check($sformatf("v%0d reads", i), nrd, vec[i].nrd);
            check($sformatf("v%0d writes", i), nwr, vec[i].nwr);
            if (vec[i].nrd + vec[i].nwr > 0)
                check($sformatf("v%0d mem_addr", i), {24'd0, last_maddr}, {24'd0, vec[i].maddr});
            if (vec[i].nwr > 0)
                check($sformatf("v%0d mem_wdata", i), last_wdata, vec[i].mwd);
        end

        // req_valid held high with changing inputs during the busy period
        @(negedge clk);
        acc0 = acc_total;
        req_valid = 1'b1;
        opcode = LW;
        addr = 32'h10;
        @(negedge clk);
        opcode = SW;
        addr = 32'h14;
        write_data = 32'hDEAD_BEEF;
        check("held busy req_ready", {31'd0, req_ready}, 32'd0);
        n = 1;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("held latency", n, 3);
        check("held load_data", load_data, 32'h8000_7F01);
        check("held accept count", acc_total - acc0, 1);
        @(negedge clk);

        // Randomized traffic against the reference model
        for (int w = 0; w < 256; w++) begin
            wd = $urandom;
            model(SW, 32'(w) << 2, wd, e_ld, e_mis, e_lat, e_rd, e_wr);
            do_req(SW, 32'(w) << 2, wd, lat, ld, mis, nrd, nwr);
        end
        for (int t = 0; t < 200; t++) begin
            op = ops[$urandom_range(0, 8)];
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (op == SB || op == LB || op == LBU) ? a[1:0] : 2'b00;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b10;
            wd = $urandom;
            model(op, a, wd, e_ld, e_mis, e_lat, e_rd, e_wr);
            do_req(op, a, wd, lat, ld, mis, nrd, nwr);
            check($sformatf("r%0d op%h a%h latency", t, op, a), lat, e_lat);
            check($sformatf("r%0d op%h a%h load_data", t, op, a), ld, e_ld);
            check($sformatf("r%0d op%h a%h misaligned", t, op, a), {31'd0, mis}, {31'd0, e_mis});
            check($sformatf("r%0d op%h a%h strobes", t, op, a), nrd * 4 + nwr, e_rd * 4 + e_wr);
        end
        bad = 0;
        for (int w = 0; w < 256; w++) if (mem[w] !== ref_mem[w]) bad++;
        check("memory image vs model", bad, 0);

        // Reset during RD_WAIT of an SB aborts the read-modify-write
        @(negedge clk);
        wr0 = wr_total;
        resp0 = resp_total;
        req_valid = 1'b1;
        opcode = SB;
        addr = 32'h15;
        write_data = 32'h0000_00AB;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort rd_wait strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("abort rd_wait resp/ready", {30'd0, resp_valid, req_ready}, 32'd0);
        check("abort rd_wait mem_addr", {24'd0, mem_addr}, 32'd0);
        check("abort rd_wait outputs", load_data | mem_wdata | {31'd0, misaligned}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort rd_wait ready after", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort rd_wait no write", wr_total - wr0, 0);
        check("abort rd_wait no resp", resp_total - resp0, 0);
        check("abort rd_wait mem word", mem[5], ref_mem[5]);

        // Reset during WR drops the write strobe immediately
        wr0 = wr_total;
        req_valid = 1'b1;
        opcode = SW;
        addr = 32'h20;
        write_data = 32'h7777_7777;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort wr strobe before", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort wr strobe dropped", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort wr no write", wr_total - wr0, 0);
        check("abort wr mem word", mem[8], ref_mem[8]);
        check("abort wr ready after", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle MEM-stage controller between the EX/MEM pipeline register and `data_memory`. Takes one load/store request at a time and drives the memory's word-addressed port, performing byte/halfword read-modify-write for stores. Returns aligned, sign-/zero-extended load data to writeback. Flags misaligned accesses without touching memory.

## Interface
- `ADDR_WIDTH`, default 8: word-index width; 256 words.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE with `reset` low; a request is accepted on `req_valid && req_ready`.
- `opcode`  in  6: MIPS opcode, one of LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- `addr`  in  32: byte address.
- `write_data`  in  32: store data; the byte/halfword is taken from the low bits.
- `resp_valid`  out  1: one-cycle completion pulse.
- `load_data`  out  32: extended load result; 0 for stores, misaligned requests and unsupported opcodes.
- `misaligned`  out  1: valid with `resp_valid`.
- `mem_addr`  out  ADDR_WIDTH: word index, `addr[ADDR_WIDTH+1:2]`.
- `mem_wdata`  out  32: full word to write.
- `mem_read`  out  1: read strobe.
- `mem_write`  out  1: write strobe.
- `mem_rdata`  in  32: valid the cycle after `mem_read`.

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- On accept, `opcode`, `addr` and `write_data` are registered. Inputs are ignored outside IDLE.
- Misalignment rules:
  - LH, LHU and SH with `addr[0]`=1 are misaligned.
  - LW and SW with `addr[1:0]`≠0 are misaligned.
  - A misaligned request goes directly to RESP with `misaligned`=1. No memory strobe is issued.
- Unsupported opcode: go to RESP with `misaligned`=0 and `load_data`=0. No strobe.
- FSM states: IDLE, RD, RD_WAIT, WR, RESP.
  - Loads: IDLE→RD→RD_WAIT→RESP→IDLE.
  - SW: IDLE→WR→RESP→IDLE.
  - SB and SH: IDLE→RD→RD_WAIT→WR→RESP→IDLE.
- `mem_read` is high exactly in RD. `mem_write` is high exactly in WR. Both are decoded from state.
- In RD_WAIT, `mem_rdata` is captured:
  - Loads: select the lane and extend into the `load_data` register.
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW passes the word through.
  - SB/SH: merge the lane into the captured word and leave all other bytes unchanged. The result is `mem_wdata` in WR.
- SW drives `mem_wdata`=`write_data` in WR.
- `addr` bits above `ADDR_WIDTH+1` are ignored; addresses wrap modulo 256 words.
- `load_data` and `misaligned` hold their value until the next accept.

## Timing
- Accept in cycle T. `resp_valid` is asserted at:
  - T+1: misaligned or unsupported opcode.
  - T+2: SW.
  - T+3: loads.
  - T+4: SB/SH.
- `req_ready` is high again the cycle after RESP. There are no back-to-back accepts.
- Reset values: state IDLE, and all outputs 0 (`req_ready`, `resp_valid`, `load_data`, `misaligned`, `mem_*`).
- Reset mid-operation aborts immediately, with no later strobe or `resp_valid`.
  - An RMW aborted before WR leaves memory untouched.
  - Reset during WR drops `mem_write` asynchronously.
- `req_valid` held high during a busy period is not accepted until IDLE.

## Structure
- Shared package `mips_mem_pkg`: opcode localparams (OP_LB … OP_SW), the `lsu_state_t` enum, and a `is_store(opcode)` function. `data_memory` reuses the opcode constants.
- One natural combinational sub-module, `load_align_ext`: (word, addr[1:0], opcode) → extended 32-bit result. It is instantiated for the RD_WAIT load path.

## Test plan
- Word `mem[4]`=0x8000_7F01. LB addr 0x10 → `load_data`=0x0000_0001. LB addr 0x13 → 0xFFFF_FF80. LBU addr 0x13 → 0x0000_0080. Each response at T+3.
- Same word:
  - LH addr 0x12 → 0xFFFF_8000.
  - LHU addr 0x12 → 0x0000_8000.
  - LW addr 0x10 → 0x8000_7F01.
- `mem[5]`=0x1122_3344. SB addr 0x15, `write_data`=0xAB:
  - one RD, then WR with `mem_wdata`=0x1122_AB44;
  - `resp_valid` at T+4;
  - an SH at addr 0x16 with 0xBEEF then gives 0xBEEF_AB44.
- Misaligned: LW addr 0x12 and SH addr 0x11 → `resp_valid` and `misaligned` at T+1, with `mem_read`/`mem_write` never asserted.
- SW addr 0x3FC (word 255), then LW addr 0x400 (wraps to word 0) → `mem_addr`=0xFF, then 0x00.
- Assert `reset` during RD_WAIT of an SB → all outputs 0 at once, no `mem_write`, memory word unchanged, `req_ready`=1 after `reset` deasserts.
